rf_write_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline writeback stage and the long-latency multiply/divide unit (MDU). A small result FIFO holds MDU results while the writeback stage owns the port. A per-register pending scoreboard produces the decode-stage stall for RAW and WAW hazards against outstanding MDU results. It sits between the WB stage, the MDU and the register file write port.

---
 rtl/rf_ctrl_pkg.sv | 19 +
 rtl/rf_result_fifo.sv | 54 +++++
 rtl/rf_write_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and widths for the register-file write-port controller.
package rf_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 1 << REG_W;
  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

  // One-hot register mask used by the pending scoreboard.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    reg_onehot = NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/rf_result_fifo.sv
// Small FIFO buffering MDU results while WB owns the register-file port.
module rf_result_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  rf_wr_t push_data,
  input  logic   pop,
  output rf_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rf_wr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB and the MDU result FIFO,
// and tracks outstanding MDU destinations to stall decode on RAW/WAW hazards.
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                mdu_issue,
  input  logic [REG_W-1:0]    mdu_issue_reg,
  input  logic                mdu_valid,
  input  logic [REG_W-1:0]    mdu_reg,
  input  logic [DATA_W-1:0]   mdu_data,
  output logic                mdu_ready,
  input  logic [REG_W-1:0]    dec_rs,
  input  logic [REG_W-1:0]    dec_rt,
  input  logic [REG_W-1:0]    dec_dst,
  output logic                stall,
  output logic                rf_write,
  output logic [REG_W-1:0]    rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] pending,
  output logic                err
);

  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  rf_wr_t              fifo_head;
  rf_wr_t              port;
  logic                fifo_full;
  logic                fifo_empty;
  logic                accept;
  logic                wb_take;
  logic                pop;
  logic [NUM_REGS-1:0] pop_mask;
  logic [NUM_REGS-1:0] visible;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [STV_W-1:0]    starve_cnt;
  logic [STV_W-1:0]    starve_nxt;
  logic                err_nxt;

  assign mdu_ready = !fifo_full;
  assign accept    = mdu_valid && mdu_ready;

  rf_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data ('{rd: mdu_reg, data: mdu_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Port grant: WB first, FIFO head when WB leaves the port free.
  always_comb begin
    wb_take  = wb_valid && (wb_reg != REG_ZERO);
    pop      = !wb_take && !fifo_empty;
    port     = '0;
    rf_write = 1'b0;
    if (wb_take) begin
      port     = '{rd: wb_reg, data: wb_data};
      rf_write = 1'b1;
    end else if (pop) begin
      port     = fifo_head;
      rf_write = (fifo_head.rd != REG_ZERO);
    end
  end

  assign rf_write_reg  = port.rd;
  assign rf_write_data = port.data;

  // The register being popped is forwarded by the RF, so it no longer blocks decode.
  always_comb begin
    pop_mask = pop ? reg_onehot(fifo_head.rd) : '0;
    visible  = pending & ~pop_mask;
    stall    = visible[dec_rs] || visible[dec_rt] || visible[dec_dst] ||
               fifo_full || (starve_cnt == STV_W'(STARVE_MAX));
  end

  always_comb begin
    pending_nxt = pending & ~pop_mask;
    if (mdu_issue && (mdu_issue_reg != REG_ZERO)) begin
      pending_nxt = pending_nxt | reg_onehot(mdu_issue_reg);
    end
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (fifo_empty || pop) begin
      starve_nxt = '0;
    end else if (wb_take && (starve_cnt != STV_W'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + STV_W'(1);
    end
  end

  always_comb begin
    err_nxt = err;
    if (accept && ((mdu_reg == REG_ZERO) || !pending[mdu_reg])) err_nxt = 1'b1;
    if (wb_valid && pending[wb_reg]) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      starve_cnt <= starve_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; a queue of accepted MDU results predicts port writes.
module tb_rf_write_arbiter;
  import rf_ctrl_pkg::*;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int          DEPTH_I    = int'(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_reg;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_dst;
  logic        stall;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] pending;
  logic        err;

  int     checks = 0;
  int     errors = 0;
  rf_wr_t mdu_q[$];
  logic   acc_now;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .mdu_issue     (mdu_issue),
    .mdu_issue_reg (mdu_issue_reg),
    .mdu_valid     (mdu_valid),
    .mdu_reg       (mdu_reg),
    .mdu_data      (mdu_data),
    .mdu_ready     (mdu_ready),
    .dec_rs        (dec_rs),
    .dec_rt        (dec_rt),
    .dec_dst       (dec_dst),
    .stall         (stall),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .pending       (pending),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    mdu_issue = 1'b0; mdu_issue_reg = 5'd0;
    mdu_valid = 1'b0; mdu_reg = 5'd0; mdu_data = 32'd0;
    dec_rs = 5'd0; dec_rt = 5'd0; dec_dst = 5'd0;
  endtask

  // Mid-cycle: predict ready and the port write from the expected FIFO model.
  task automatic sample();
    rf_wr_t e;
    logic   exp_ready;
    @(negedge clk);
    exp_ready = (mdu_q.size() < DEPTH_I);
    chkb("mdu_ready", mdu_ready, exp_ready);
    acc_now = mdu_valid && exp_ready;
    if (wb_valid && (wb_reg != 5'd0)) begin
      chkb("wb_write", rf_write, 1'b1);
      chkw("wb_reg", 32'(rf_write_reg), 32'(wb_reg));
      chkw("wb_data", rf_write_data, wb_data);
    end else if (mdu_q.size() > 0) begin
      e = mdu_q.pop_front();
      chkb("mdu_write", rf_write, (e.rd != 5'd0));
      if (e.rd != 5'd0) begin
        chkw("mdu_reg", 32'(rf_write_reg), 32'(e.rd));
        chkw("mdu_data", rf_write_data, e.data);
      end
    end else begin
      chkb("idle_write", rf_write, 1'b0);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (acc_now && reset) mdu_q.push_back('{rd: mdu_reg, data: mdu_data});
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    mdu_q.delete();
    sample();
    chkw("rst_pending", pending, 32'd0);
    chkb("rst_err", err, 1'b0);
    chkb("rst_stall", stall, 1'b0);
    advance();
    reset = 1'b1;
  endtask

  initial begin
    acc_now = 1'b0;
    idle();
    @(posedge clk); #1;
    apply_reset();

    // RAW stall on r5 until its pop cycle
    mdu_issue = 1'b1; mdu_issue_reg = 5'd5; dec_rs = 5'd5;
    sample(); chkb("t1_issue_stall", stall, 1'b0); advance();
    mdu_issue = 1'b0;
    sample(); chkb("t1_rs_stall", stall, 1'b1); chkw("t1_pending", pending, 32'h0000_0020); advance();
    dec_rs = 5'd0; dec_rt = 5'd5;
    sample(); chkb("t1_rt_stall", stall, 1'b1); advance();
    dec_rt = 5'd0; dec_dst = 5'd5;
    sample(); chkb("t1_dst_stall", stall, 1'b1); advance();
    dec_dst = 5'd6;
    sample(); chkb("t1_other_stall", stall, 1'b0); advance();
    dec_dst = 5'd0; dec_rs = 5'd5;
    mdu_valid = 1'b1; mdu_reg = 5'd5; mdu_data = 32'h1234_5678;
    sample(); chkb("t1_accept_stall", stall, 1'b1); advance();
    mdu_valid = 1'b0;
    sample(); chkb("t1_pop_stall", stall, 1'b0); advance();
    sample(); chkb("t1_after_stall", stall, 1'b0); chkw("t1_cleared", pending, 32'd0); advance();
    idle();

    // r7 result held while WB writes r3
    mdu_issue = 1'b1; mdu_issue_reg = 5'd7; cyc(); mdu_issue = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hA000_0000;
    mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'hDEAD_BEEF;
    cyc();
    mdu_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      wb_data = 32'hA000_0000 + 32'(i);
      sample(); chkb("t2_hold_stall", stall, 1'b0); advance();
    end
    wb_valid = 1'b0;
    sample();
    chkw("t2_port_reg", 32'(rf_write_reg), 32'd7);
    chkw("t2_port_data", rf_write_data, 32'hDEAD_BEEF);
    chkw("t2_pend_at_pop", pending, 32'h0000_0080);
    advance();
    sample(); chkw("t2_pend_after", pending, 32'd0); advance();
    idle();

    // Fill the FIFO under continuous WB, then one bubble
    mdu_issue = 1'b1; mdu_issue_reg = 5'd10; cyc();
    mdu_issue_reg = 5'd11; cyc(); mdu_issue = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_3333;
    mdu_valid = 1'b1; mdu_reg = 5'd10; mdu_data = 32'h0000_0A0A; cyc();
    mdu_reg = 5'd11; mdu_data = 32'h0000_0B0B; cyc();
    mdu_valid = 1'b0;
    sample(); chkb("t3_full_ready", mdu_ready, 1'b0); chkb("t3_full_stall", stall, 1'b1); advance();
    wb_valid = 1'b0;
    sample(); chkb("t3_bubble_stall", stall, 1'b1); advance();
    wb_valid = 1'b1;
    sample(); chkb("t3_after_ready", mdu_ready, 1'b1); chkb("t3_after_stall", stall, 1'b0); advance();
    wb_valid = 1'b0; cyc(); cyc();
    idle();

    // Starvation: WB busy with FIFO non-empty forces a drain stall
    mdu_issue = 1'b1; mdu_issue_reg = 5'd12; cyc(); mdu_issue = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_4444;
    mdu_valid = 1'b1; mdu_reg = 5'd12; mdu_data = 32'h0000_0C0C; cyc();
    mdu_valid = 1'b0;
    for (int i = 0; i < int'(STARVE_MAX); i++) begin
      sample(); chkb("t4_pre_stall", stall, 1'b0); advance();
    end
    sample(); chkb("t4_starve_stall", stall, 1'b1); advance();
    sample(); chkb("t4_sat_stall", stall, 1'b1); advance();
    wb_valid = 1'b0;
    sample(); chkb("t4_pop_stall", stall, 1'b1); advance();
    sample(); chkb("t4_release_stall", stall, 1'b0); chkb("t4_err", err, 1'b0); advance();
    idle();

    // Protocol errors: unpending accept, accept to r0, WB to a pending register
    mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'h0000_0909;
    sample(); chkb("t5_err_before", err, 1'b0); advance();
    mdu_valid = 1'b0;
    sample(); chkb("t5_err_set", err, 1'b1); advance();
    sample(); chkb("t5_err_held", err, 1'b1); advance();
    apply_reset();
    mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h0000_00FF;
    sample(); chkb("t5_r0_before", err, 1'b0); advance();
    mdu_valid = 1'b0;
    sample(); chkb("t5_r0_err", err, 1'b1); advance();
    apply_reset();
    mdu_issue = 1'b1; mdu_issue_reg = 5'd20; cyc(); mdu_issue = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd20; wb_data = 32'h0000_2020;
    sample(); chkb("t5_wb_before", err, 1'b0); advance();
    wb_valid = 1'b0;
    sample(); chkb("t5_wb_err", err, 1'b1); advance();
    idle();

    // Reset mid-drain with two results queued
    mdu_issue = 1'b1; mdu_issue_reg = 5'd13; cyc();
    mdu_issue_reg = 5'd14; cyc(); mdu_issue = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_5555;
    mdu_valid = 1'b1; mdu_reg = 5'd13; mdu_data = 32'h0000_0D0D; cyc();
    mdu_reg = 5'd14; mdu_data = 32'h0000_0E0E; cyc();
    mdu_valid = 1'b0; wb_valid = 1'b0;
    sample(); chkw("t6_pend_drain", pending, 32'h0010_6000); advance();
    reset = 1'b0;
    mdu_q.delete();
    #1;
    chkb("t6_rst_write", rf_write, 1'b0);
    chkw("t6_rst_pending", pending, 32'd0);
    sample(); chkb("t6_rst_err", err, 1'b0); chkb("t6_rst_stall", stall, 1'b0); advance();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
